iob_uart_tx_fifo: RTL
=====================

# iob_uart_tx_fifo

Transmit buffer between the UART CPU-side register file and `uart_core`. It stores TXDATA writes in a FIFO so software can queue several bytes without polling TXREADY. A drain state machine hands one byte at a time to `uart_core` (`tx_data_i` / `data_write_en_i`) whenever the core reports `tx_ready_o`. It also provides fill level, a low-water threshold flag for interrupts, and a sticky overflow flag.

## Interface
- `DATA_W`, 8, width of one character (matches UART_DATA_W)
- `ADDR_W`, 4, log2 of FIFO depth; depth = 2**ADDR_W = 16
- `clk_i`  in  1  system clock
- `arst_n_i`  in  1  asynchronous active-low reset; one clock domain; all state is cleared on assertion
- `soft_rst_i`  in  1  synchronous clear, driven by SOFTRESET
- `en_i`  in  1  drain enable, driven by TXEN
- `wr_en_i`  in  1  push strobe (TXDATA write)
- `wr_data_i`  in  DATA_W  push data
- `full_o`  out  1  FIFO holds 2**ADDR_W entries
- `empty_o`  out  1  FIFO holds 0 entries
- `level_o`  out  ADDR_W+1  current entry count
- `thresh_i`  in  ADDR_W+1  low-water threshold
- `below_thresh_o`  out  1  `level_o < thresh_i` (combinational from the level register)
- `overflow_o`  out  1  sticky; set by a push while full
- `ovf_clr_i`  in  1  clears `overflow_o`
- `core_ready_i`  in  1  from uart_core `tx_ready_o`
- `core_wen_o`  out  1  to uart_core `data_write_en_i`; one-cycle pulse
- `core_data_o`  out  DATA_W  to uart_core `tx_data_i`; registered

## Operation
- **Storage**
  - Storage is a 2**ADDR_W x DATA_W register array.
  - Write pointer, read pointer and count are ADDR_W, ADDR_W and ADDR_W+1 bits wide.
  - Pointers wrap naturally modulo depth.
- **Push**
  - A push is accepted when `wr_en_i && !full_o`: `mem[wptr] <= wr_data_i`, `wptr++`.
  - `wr_en_i && full_o` drops the data and sets `overflow_o`.
  - Full is judged on the start-of-cycle count. A push while full is dropped even if a pop happens in the same cycle.
- **Pop**
  - A pop happens only in the drain FSM IDLE→ISSUE transition.
  - Count update per cycle: +1 for an accepted push, -1 for a pop, unchanged for both.
- **Drain FSM**: states IDLE, ISSUE, GAP.
  - IDLE: if `en_i && !empty_o && core_ready_i`, load `core_data_o <= mem[rptr]`, `rptr++`, go to ISSUE. Otherwise stay.
  - ISSUE: `core_wen_o = 1` for exactly this cycle. `core_data_o` stays stable. Go to GAP.
  - GAP: one cycle with `core_wen_o = 0`, giving uart_core time to drop `tx_ready_o`. Return to IDLE.
  - uart_core must deassert `tx_ready_o` no later than the cycle after the `data_write_en_i` pulse. IDLE then waits for it to rise again.
- **`en_i` deasserted**
  - An in-flight ISSUE/GAP completes.
  - No new pop is started.
  - Contents are retained.
- **`soft_rst_i`**
  - Clears pointers, count, `overflow_o` and `core_data_o`, and forces the FSM to IDLE with `core_wen_o = 0`.
  - It overrides a push, a pop and `ovf_clr_i` in the same cycle.
- **Overflow**
  - `ovf_clr_i` clears `overflow_o`.
  - If a clear and a new overflow happen in the same cycle, set wins.

## Timing
- **Reset values** (`arst_n_i` low):
  - `level_o = 0`, `empty_o = 1`, `full_o = 0`, `overflow_o = 0`
  - `core_wen_o = 0`, `core_data_o = 0`, FSM = IDLE
  - `below_thresh_o = (thresh_i != 0)`
- **Flag updates**: `full_o`, `empty_o` and `level_o` are registered. They update on the edge after the push or pop.
- **First-byte latency**: with the FIFO empty, `en_i = 1` and `core_ready_i = 1`:
  - push sampled at edge N;
  - count nonzero after N;
  - pop at edge N+1;
  - `core_wen_o` high during cycle N+1..N+2.
  - Latency is 2 cycles from push to core write.
- **Back-to-back rate**: with `core_ready_i` held high, one byte every 3 cycles at most (IDLE, ISSUE, GAP).
- **Reset mid-operation**: asserting `arst_n_i` or `soft_rst_i` during ISSUE aborts the pulse on the next edge. The popped byte is lost.

## Test plan
- **Reset check**: reset, then release with `thresh_i = 4` → `empty_o = 1`, `level_o = 0`, `below_thresh_o = 1`, `core_wen_o = 0`, `core_data_o = 0x00`.
- **Ordering**: push 0x41, 0x42, 0x43 with `en_i = 1` and a uart_core model where ready drops for 10 cycles after each write → `core_wen_o` pulses carry 0x41, 0x42, 0x43 in order, each exactly 1 cycle wide; the first pulse comes 2 cycles after the first push.
- **Full and overflow**: with `en_i = 0`, push 16 bytes → `full_o = 1`, `level_o = 16`. Push 0xFF → dropped and `overflow_o = 1`. Enable drain → 16 bytes out with no 0xFF. Pulse `ovf_clr_i` → `overflow_o = 0`.
- **Wrap-around**: push 12, drain 12, push 12 more (pointers wrap) → all 24 bytes out in order; `level_o` never exceeds 12.
- **Simultaneous push and pop**: level 5, push in the same cycle as the IDLE→ISSUE pop → `level_o` stays 5. Push while full in the same cycle as a pop → data dropped, `overflow_o = 1`, level 15.
- **`en_i` and soft reset**: level 6, deassert `en_i` during ISSUE → pulse completes, `level_o = 5`, no further pulses. Then assert `soft_rst_i` → `level_o = 0`, `empty_o = 1`, `overflow_o = 0`, FSM in IDLE.

Source files
------------

// File: rtl/iob_uart_tx_fifo_if.sv
// CPU-side push/status signals and uart_core handoff signals of the UART transmit FIFO.
// The slave modport is the FIFO itself; the master modport is whoever drives it.
interface iob_uart_tx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_en_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              full_o;
  logic              empty_o;
  logic [ADDR_W:0]   level_o;
  logic [ADDR_W:0]   thresh_i;
  logic              below_thresh_o;
  logic              overflow_o;
  logic              ovf_clr_i;
  logic              core_ready_i;
  logic              core_wen_o;
  logic [DATA_W-1:0] core_data_o;

  modport slave (
    input  wr_en_i, wr_data_i, thresh_i, ovf_clr_i, core_ready_i,
    output full_o, empty_o, level_o, below_thresh_o, overflow_o,
           core_wen_o, core_data_o
  );

  modport master (
    output wr_en_i, wr_data_i, thresh_i, ovf_clr_i, core_ready_i,
    input  full_o, empty_o, level_o, below_thresh_o, overflow_o,
           core_wen_o, core_data_o
  );
endinterface

// File: rtl/iob_uart_tx_fifo.sv
// UART transmit FIFO: buffers TXDATA writes and drains them one byte at a time into
// uart_core through an IDLE/ISSUE/GAP handshake, with level, low-water and overflow flags.
module iob_uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                soft_rst_i,
  input  logic                en_i,
  iob_uart_tx_fifo_if.slave   bus
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;
  logic              full;
  logic              empty;
  logic              overflow;
  state_t            state;
  logic              core_wen;
  logic [DATA_W-1:0] core_data;

  logic push;
  logic pop;

  // Full and empty are the registered start-of-cycle flags, so a push while full is
  // dropped even when a pop frees a slot on the same edge.
  assign push = bus.wr_en_i && !full;
  assign pop  = (state == IDLE) && en_i && !empty && bus.core_ready_i;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (soft_rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
    end
  end

  // NOTE: the storage array has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push && !soft_rst_i) begin
      mem[wptr] <= bus.wr_data_i;
    end
  end

  // Set beats clear when both arrive together.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      overflow <= 1'b0;
    end else if (soft_rst_i) begin
      overflow <= 1'b0;
    end else if (bus.wr_en_i && full) begin
      overflow <= 1'b1;
    end else if (bus.ovf_clr_i) begin
      overflow <= 1'b0;
    end
  end

  // Drain FSM: the write-enable pulse is registered so it is high for exactly the ISSUE
  // cycle; GAP gives uart_core one cycle to drop its ready before IDLE looks again.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state     <= IDLE;
      core_wen  <= 1'b0;
      core_data <= '0;
    end else if (soft_rst_i) begin
      state     <= IDLE;
      core_wen  <= 1'b0;
      core_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          core_wen <= 1'b0;
          if (pop) begin
            core_data <= mem[rptr];
            core_wen  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          core_wen <= 1'b0;
          state    <= GAP;
        end
        GAP: begin
          core_wen <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          core_wen <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.level_o        = count;
  assign bus.below_thresh_o = (count < bus.thresh_i);
  assign bus.overflow_o     = overflow;
  assign bus.core_wen_o     = core_wen;
  assign bus.core_data_o    = core_data;

endmodule
